// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: request/grant/read-return bundle for one BRAM requester port.
interface bram_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares a single-port BRAM between two requesters with round-robin
// arbitration, a port-1 lock mode and read-data return routed by an in-flight tag pipeline.
module bram_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_port_arbiter_if.slave    port0,
    bram_port_arbiter_if.slave    port1,
    input  logic                  i_lock1,
    output logic                  o_locked,
    output logic                  o_bram_ena,
    output logic                  o_bram_wea,
    output logic [ADDR_WIDTH-1:0] o_bram_addra,
    output logic [DATA_WIDTH-1:0] o_bram_dina,
    input  logic [DATA_WIDTH-1:0] i_bram_douta
);
    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_ptr, w_ptr_nxt;
    logic                    w_gnt0, w_gnt1;
    logic                    w_rd_v, w_rv;
    logic [READ_LATENCY-1:0] r_tag_v, r_tag_p;
    logic [DATA_WIDTH-1:0]   r_rdata0, r_rdata1;

    // r_ptr names the port that wins the next contended ARB cycle
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (!rst) begin
            if (r_state == ST_LOCK) begin
                w_gnt1 = port1.req;
                if (!i_lock1) begin
                    w_state_nxt = ST_ARB;
                    w_ptr_nxt   = 1'b0;
                end
            end else begin
                w_gnt0    = port0.req && (!port1.req || !r_ptr);
                w_gnt1    = port1.req && !w_gnt0;
                w_ptr_nxt = w_gnt0 ? 1'b1 : w_gnt1 ? 1'b0 : r_ptr;
                if (w_gnt1 && i_lock1)
                    w_state_nxt = ST_LOCK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ARB;
            r_ptr    <= 1'b0;
            r_tag_v  <= '0;
            r_tag_p  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_tag_v[0] <= w_rd_v;
            r_tag_p[0] <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end
            r_rdata0 <= port0.rvalid ? i_bram_douta : r_rdata0;
            r_rdata1 <= port1.rvalid ? i_bram_douta : r_rdata1;
        end
    end

    assign w_rd_v       = (w_gnt0 && !port0.we) || (w_gnt1 && !port1.we);
    assign w_rv         = r_tag_v[READ_LATENCY-1] && !rst;
    assign port0.gnt    = w_gnt0;
    assign port1.gnt    = w_gnt1;
    assign port0.rvalid = w_rv && !r_tag_p[READ_LATENCY-1];
    assign port1.rvalid = w_rv && r_tag_p[READ_LATENCY-1];
    // returning data passes straight through; the hold register keeps it afterwards
    assign port0.rdata  = port0.rvalid ? i_bram_douta : r_rdata0;
    assign port1.rdata  = port1.rvalid ? i_bram_douta : r_rdata1;
    assign o_locked     = (r_state == ST_LOCK) && !rst;
    assign o_bram_ena   = w_gnt0 || w_gnt1;
    assign o_bram_wea   = w_gnt0 ? port0.we : w_gnt1 ? port1.we : 1'b0;
    assign o_bram_addra = w_gnt0 ? port0.addr : w_gnt1 ? port1.addr : '0;
    assign o_bram_dina  = w_gnt0 ? port0.wdata : w_gnt1 ? port1.wdata : '0;
endmodule
